fifo_sync_capture: RTL and testbench
====================================

Name: fifo_sync_capture

Overview:
Parametrised single-clock capture FIFO for frontends whose capture and readout share fe_clk. It generalises the shared capture FIFO with configurable width and depth, runtime-programmable full/empty thresholds, a fill-level output, and a circular overwrite mode that keeps the most recent DEPTH words for pre-trigger capture. Status word layout matches the existing FIFO_STAT_* defines, so reg_main readout is unchanged.

Parameters:
WIDTH, 18, data word width in bits.
DEPTH, 1024, storage depth in words; power of two, minimum 4.
AW, $clog2(DEPTH), address width; derived, do not override.
DROP_W, 16, width of the dropped-word counter.

Ports:
fe_clk  in  1  sole clock.
reset_n  in  1  asynchronous active-low reset.
I_data  in  WIDTH  write data.
I_wr  in  1  write strobe.
I_fifo_read  in  1  read strobe.
I_fifo_flush  in  1  synchronous flush.
I_overwrite_mode  in  1  1 = circular mode (drop oldest on full), 0 = block on full.
I_full_threshold  in  AW+1  programmable full level.
I_empty_threshold  in  AW+1  programmable empty level.
I_custom_fifo_stat_flag  in  1  passed through to status.
I_clear_read_flags  in  1  clears underflow sticky.
I_clear_write_flags  in  1  clears overflow_blocked sticky and dropped counter.
O_data  out  WIDTH  read data, registered.
O_fifo_count  out  AW+1  current fill level, 0..DEPTH.
O_fifo_full  out  1  count == DEPTH.
O_fifo_empty  out  1  count == 0.
O_fifo_overflow_blocked  out  1  sticky: a write was refused.
O_dropped_count  out  DROP_W  words discarded in overwrite mode, saturating.
O_fifo_status  out  6  status word.

Behaviour:
- Reset (reset_n low, async assert, sync release): pointers, count, stickies, dropped count = 0; O_data = 0; O_fifo_empty = 1; all other flags 0.
- Storage: inferred RAM, DEPTH x WIDTH; pointers AW bits wrap modulo DEPTH; count tracked separately at AW+1 bits.
- Read: I_fifo_read with count>0 -> O_data valid the next cycle (1-cycle latency, standard mode, not FWFT); rd_ptr++. With count==0: no pointer change, O_data holds, underflow sticky set.
- Write, not full: stored at wr_ptr; wr_ptr++.
- Write, full, overwrite=0: refused; overflow_blocked set; no state change.
- Write, full, overwrite=1: accepted; rd_ptr++ (oldest discarded); count stays DEPTH; dropped_count++ saturating at 2^DROP_W-1.
- Read and write in the same cycle:
  - count 0: write accepted, read underflows.
  - 0<count<DEPTH: both proceed, count unchanged.
  - count DEPTH: both accepted in either mode; no drop, no block flag.
- Count update: +1 on accepted write only, -1 on accepted read only, otherwise unchanged. Combinational flags derive from the registered count.
- Flush: I_fifo_flush zeroes pointers and count in one cycle; count==0 and empty==1 the next cycle. Flush overrides I_wr and I_fifo_read that cycle. Sticky flags and dropped count are not cleared. O_data holds.
- Stickies: set has priority over clear in the same cycle.
- Thresholds:
  - full_threshold = (count >= I_full_threshold).
  - empty_threshold = (count <= I_empty_threshold) & ~empty.
  - Threshold inputs are sampled every cycle and may change at any time.
- O_fifo_status bits, per FIFO_STAT_* defines: EMPTY = O_fifo_empty, UNDERFLOW = sticky, EMPTY_THRESHOLD = empty_threshold, FULL = O_fifo_full, OVERFLOW_BLOCKED = sticky, CUSTOM_FLAG = I_custom_fifo_stat_flag.
- Mode switch mid-stream is allowed and takes effect the same cycle. Contents are preserved.
- Reset mid-operation: immediate return to reset state. Data in RAM is don't-care.

Test Plan:
- WIDTH=18, DEPTH=16: write 0x00001..0x00010, then 16 reads -> O_data 0x00001..0x00010 in order, each one cycle after its read; empty=1 after the last read; count 16->0.
- Full with overwrite=0: 17th write 0x3FFFF -> refused, overflow_blocked=1, count=16; readback excludes 0x3FFFF; I_clear_write_flags -> flag 0.
- Overwrite=1: 20 writes of values 1..20 -> dropped_count=4, count=16; readback yields 5..20.
- Read on empty -> UNDERFLOW status bit=1, O_data unchanged. Assert I_clear_read_flags on the same cycle as a second underflow -> flag stays 1.
- I_empty_threshold=3, I_full_threshold=12: step count 0..16 -> EMPTY_THRESHOLD high only for count 1..3; full_threshold high for count 12..16. Flush at count 9 with I_wr=1 -> count=0 next cycle, the write is dropped.
- Assert reset_n low asynchronously mid-burst (count=7) -> all outputs return to reset values without a clock edge; after release, normal writes resume at count 0.

Source files
------------

// File: rtl/fifo_sync_capture.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_capture
// Description : Single-clock capture FIFO with programmable thresholds,
//               fill level and a circular overwrite (pre-trigger) mode.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_capture #(
    parameter int WIDTH  = 18,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH),
    parameter int DROP_W = 16
) (
    input  logic              fe_clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  I_data,
    input  logic              I_wr,
    input  logic              I_fifo_read,
    input  logic              I_fifo_flush,
    input  logic              I_overwrite_mode,
    input  logic [AW:0]       I_full_threshold,
    input  logic [AW:0]       I_empty_threshold,
    input  logic              I_custom_fifo_stat_flag,
    input  logic              I_clear_read_flags,
    input  logic              I_clear_write_flags,
    output logic [WIDTH-1:0]  O_data,
    output logic [AW:0]       O_fifo_count,
    output logic              O_fifo_full,
    output logic              O_fifo_empty,
    output logic              O_fifo_overflow_blocked,
    output logic [DROP_W-1:0] O_dropped_count,
    output logic [5:0]        O_fifo_status,
    output logic              O_fifo_full_threshold,
    output logic              O_fifo_empty_threshold
);

    localparam logic [AW:0]       c_depth_cnt = (AW+1)'(DEPTH);
    localparam logic [DROP_W-1:0] c_drop_max  = '1;
    localparam logic [AW-1:0]     c_ptr_one   = AW'(1);

    localparam int c_stat_empty      = 0;
    localparam int c_stat_underflow  = 1;
    localparam int c_stat_empty_thr  = 2;
    localparam int c_stat_full       = 3;
    localparam int c_stat_overflow   = 4;
    localparam int c_stat_custom     = 5;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [AW:0]       count_q,     count_d;
    logic [WIDTH-1:0]  data_q,      data_d;
    logic              underflow_q, underflow_d;
    logic              overflow_q,  overflow_d;
    logic [DROP_W-1:0] dropped_q,   dropped_d;

    logic w_empty, w_full;
    logic w_wr_req, w_rd_req;
    logic w_rd_ok, w_wr_ok, w_drop, w_block, w_underflow_set;
    logic w_inc, w_dec;

    always_comb begin
        w_empty  = (count_q == '0);
        w_full   = (count_q == c_depth_cnt);
        // Flush masks both strobes so nothing else moves that cycle
        w_wr_req = I_wr & ~I_fifo_flush;
        w_rd_req = I_fifo_read & ~I_fifo_flush;

        w_rd_ok         = w_rd_req & ~w_empty;
        w_underflow_set = w_rd_req & w_empty;
        w_wr_ok         = w_wr_req & (~w_full | w_rd_ok | I_overwrite_mode);
        w_drop          = w_wr_req & w_full & ~w_rd_req & I_overwrite_mode;
        w_block         = w_wr_req & w_full & ~w_rd_req & ~I_overwrite_mode;

        w_inc = w_wr_ok & ~w_rd_ok & ~w_drop;
        w_dec = w_rd_ok & ~w_wr_ok;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_d      = data_q;
        underflow_d = w_underflow_set | (underflow_q & ~I_clear_read_flags);
        overflow_d  = w_block | (overflow_q & ~I_clear_write_flags);
        dropped_d   = dropped_q;

        if (I_fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_wr_ok) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            // A circular-mode drop retires the oldest word exactly like a read
            if (w_rd_ok || w_drop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            if (w_rd_ok) begin
                data_d = mem[rd_ptr_q];
            end
            if (w_inc) begin
                count_d = count_q + 1'b1;
            end else if (w_dec) begin
                count_d = count_q - 1'b1;
            end
        end

        if (w_drop) begin
            if (dropped_q != c_drop_max) begin
                dropped_d = dropped_q + 1'b1;
            end
        end else if (I_clear_write_flags) begin
            dropped_d = '0;
        end
    end

    always_ff @(posedge fe_clk) begin
        if (w_wr_ok) begin
            mem[wr_ptr_q] <= I_data;
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            dropped_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            dropped_q   <= dropped_d;
        end
    end

    always_comb begin
        O_data                  = data_q;
        O_fifo_count            = count_q;
        O_fifo_full             = w_full;
        O_fifo_empty            = w_empty;
        O_fifo_overflow_blocked = overflow_q;
        O_dropped_count         = dropped_q;
        O_fifo_full_threshold   = (count_q >= I_full_threshold);
        O_fifo_empty_threshold  = (count_q <= I_empty_threshold) & ~w_empty;

        O_fifo_status                   = '0;
        O_fifo_status[c_stat_empty]     = w_empty;
        O_fifo_status[c_stat_underflow] = underflow_q;
        O_fifo_status[c_stat_empty_thr] = O_fifo_empty_threshold;
        O_fifo_status[c_stat_full]      = w_full;
        O_fifo_status[c_stat_overflow]  = overflow_q;
        O_fifo_status[c_stat_custom]    = I_custom_fifo_stat_flag;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_capture
// Description : Directed scoreboard bench for fifo_sync_capture (18 x 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_capture;

    localparam int WIDTH  = 18;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int DROP_W = 16;

    logic              fe_clk = 1'b0;
    logic              reset_n;
    logic [WIDTH-1:0]  I_data;
    logic              I_wr, I_fifo_read, I_fifo_flush, I_overwrite_mode;
    logic [AW:0]       I_full_threshold, I_empty_threshold;
    logic              I_custom_fifo_stat_flag, I_clear_read_flags, I_clear_write_flags;
    logic [WIDTH-1:0]  O_data;
    logic [AW:0]       O_fifo_count;
    logic              O_fifo_full, O_fifo_empty, O_fifo_overflow_blocked;
    logic [DROP_W-1:0] O_dropped_count;
    logic [5:0]        O_fifo_status;
    logic              O_fifo_full_threshold, O_fifo_empty_threshold;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] sb_exp;
    logic             rd_expect = 1'b0;
    logic             rd_chk    = 1'b0;

    always #5 fe_clk = ~fe_clk;

    fifo_sync_capture #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) u_dut (
        .fe_clk                  (fe_clk),
        .reset_n                 (reset_n),
        .I_data                  (I_data),
        .I_wr                    (I_wr),
        .I_fifo_read             (I_fifo_read),
        .I_fifo_flush            (I_fifo_flush),
        .I_overwrite_mode        (I_overwrite_mode),
        .I_full_threshold        (I_full_threshold),
        .I_empty_threshold       (I_empty_threshold),
        .I_custom_fifo_stat_flag (I_custom_fifo_stat_flag),
        .I_clear_read_flags      (I_clear_read_flags),
        .I_clear_write_flags     (I_clear_write_flags),
        .O_data                  (O_data),
        .O_fifo_count            (O_fifo_count),
        .O_fifo_full             (O_fifo_full),
        .O_fifo_empty            (O_fifo_empty),
        .O_fifo_overflow_blocked (O_fifo_overflow_blocked),
        .O_dropped_count         (O_dropped_count),
        .O_fifo_status           (O_fifo_status),
        .O_fifo_full_threshold   (O_fifo_full_threshold),
        .O_fifo_empty_threshold  (O_fifo_empty_threshold)
    );

    // Read data is due one edge after the read strobe; check it mid-cycle
    always @(posedge fe_clk) rd_chk <= rd_expect;

    always @(negedge fe_clk) begin
        if (rd_chk) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_read got=%h expected=none", O_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (O_data !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_read_data got=%h expected=%h", O_data, sb_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; has_exp queues the data the read must return
    task automatic tick(input logic wr, input logic [WIDTH-1:0] d, input logic rd,
                        input logic has_exp, input logic [WIDTH-1:0] e);
        I_wr        = wr;
        I_data      = d;
        I_fifo_read = rd;
        if (has_exp) begin
            exp_q.push_back(e);
            rd_expect = 1'b1;
        end
        @(posedge fe_clk);
        #1;
        I_wr                = 1'b0;
        I_fifo_read         = 1'b0;
        I_fifo_flush        = 1'b0;
        I_clear_read_flags  = 1'b0;
        I_clear_write_flags = 1'b0;
        rd_expect           = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n                 = 1'b0;
        I_data                  = '0;
        I_wr                    = 1'b0;
        I_fifo_read             = 1'b0;
        I_fifo_flush            = 1'b0;
        I_overwrite_mode        = 1'b0;
        I_full_threshold        = 5'd16;
        I_empty_threshold       = 5'd0;
        I_custom_fifo_stat_flag = 1'b0;
        I_clear_read_flags      = 1'b0;
        I_clear_write_flags     = 1'b0;
        repeat (2) @(posedge fe_clk);
        #1;
        chk("rst_count", O_fifo_count, 0);
        chk("rst_empty", O_fifo_empty, 1);
        chk("rst_data", O_data, 0);
        chk("rst_status", O_fifo_status, 6'b000001);
        reset_n = 1'b1;
        @(posedge fe_clk);
        #1;

        // In-order fill and drain
        for (int i = 1; i <= 16; i++) tick(1'b1, 18'(i), 1'b0, 1'b0, '0);
        chk("fill_count", O_fifo_count, 16);
        chk("fill_full", O_fifo_full, 1);
        chk("fill_status", O_fifo_status, 6'b001000);
        for (int i = 1; i <= 16; i++) tick(1'b0, '0, 1'b1, 1'b1, 18'(i));
        chk("drain_count", O_fifo_count, 0);
        chk("drain_empty", O_fifo_empty, 1);

        // Blocking mode refuses the 17th word
        for (int i = 1; i <= 16; i++) tick(1'b1, 18'h100 + 18'(i), 1'b0, 1'b0, '0);
        tick(1'b1, 18'h3FFFF, 1'b0, 1'b0, '0);
        chk("block_flag", O_fifo_overflow_blocked, 1);
        chk("block_count", O_fifo_count, 16);
        chk("block_status", O_fifo_status, 6'b011000);
        I_clear_write_flags = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0, '0);
        chk("block_clear", O_fifo_overflow_blocked, 0);
        for (int i = 1; i <= 16; i++) tick(1'b0, '0, 1'b1, 1'b1, 18'h100 + 18'(i));

        // Circular mode keeps the newest 16 of 20
        I_overwrite_mode = 1'b1;
        for (int i = 1; i <= 20; i++) tick(1'b1, 18'(i), 1'b0, 1'b0, '0);
        chk("ovw_dropped", O_dropped_count, 4);
        chk("ovw_count", O_fifo_count, 16);
        chk("ovw_blocked", O_fifo_overflow_blocked, 0);
        I_overwrite_mode = 1'b0;
        for (int i = 5; i <= 20; i++) tick(1'b0, '0, 1'b1, 1'b1, 18'(i));

        // Underflow: data holds, set beats clear
        tick(1'b0, '0, 1'b1, 1'b1, 18'd20);
        chk("udf_status", O_fifo_status, 6'b000011);
        I_clear_write_flags = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0, '0);
        chk("drop_clear", O_dropped_count, 0);
        I_clear_read_flags = 1'b1;
        tick(1'b0, '0, 1'b1, 1'b1, 18'd20);
        chk("udf_set_wins", O_fifo_status[1], 1);
        I_clear_read_flags = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0, '0);
        chk("udf_clear", O_fifo_status, 6'b000001);
        I_custom_fifo_stat_flag = 1'b1;
        #1;
        chk("custom_flag", O_fifo_status, 6'b100001);
        I_custom_fifo_stat_flag = 1'b0;

        // Threshold sweep 0..16
        I_empty_threshold = 5'd3;
        I_full_threshold  = 5'd12;
        #1;
        chk("thr0_empty", O_fifo_empty_threshold, 0);
        chk("thr0_full", O_fifo_full_threshold, 0);
        for (int c = 1; c <= 16; c++) begin
            tick(1'b1, 18'h200 + 18'(c), 1'b0, 1'b0, '0);
            chk($sformatf("thr_empty_c%0d", c), O_fifo_empty_threshold, (c <= 3) ? 1 : 0);
            chk($sformatf("thr_full_c%0d", c), O_fifo_full_threshold, (c >= 12) ? 1 : 0);
            chk($sformatf("thr_stat_c%0d", c), O_fifo_status[2], (c <= 3) ? 1 : 0);
        end

        // Read+write together at full: neither blocked nor dropped
        tick(1'b1, 18'h2FF, 1'b1, 1'b1, 18'h201);
        chk("rw_full_count", O_fifo_count, 16);
        chk("rw_full_block", O_fifo_overflow_blocked, 0);
        for (int i = 2; i <= 8; i++) tick(1'b0, '0, 1'b1, 1'b1, 18'h200 + 18'(i));
        chk("pre_flush_count", O_fifo_count, 9);

        // Flush wins over a concurrent write
        I_fifo_flush = 1'b1;
        tick(1'b1, 18'h3AB, 1'b0, 1'b0, '0);
        chk("flush_count", O_fifo_count, 0);
        chk("flush_empty", O_fifo_empty, 1);
        tick(1'b1, 18'hAAA, 1'b0, 1'b0, '0);
        chk("post_flush_count", O_fifo_count, 1);
        tick(1'b0, '0, 1'b1, 1'b1, 18'hAAA);
        tick(1'b0, '0, 1'b1, 1'b1, 18'hAAA);

        // Asynchronous reset mid-burst
        for (int i = 1; i <= 7; i++) tick(1'b1, 18'h300 + 18'(i), 1'b0, 1'b0, '0);
        chk("burst_count", O_fifo_count, 7);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_count", O_fifo_count, 0);
        chk("arst_empty", O_fifo_empty, 1);
        chk("arst_data", O_data, 0);
        chk("arst_status", O_fifo_status, 6'b000001);
        chk("arst_dropped", O_dropped_count, 0);
        reset_n = 1'b1;
        @(posedge fe_clk);
        #1;
        tick(1'b1, 18'h055, 1'b0, 1'b0, '0);
        chk("resume_count", O_fifo_count, 1);
        tick(1'b0, '0, 1'b1, 1'b1, 18'h055);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge fe_clk);
        @(negedge fe_clk);
        chk("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
